// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one single-port synchronous memory between the
// instruction-fetch (I) and load/store (D) ports; one access in flight at a time.
module mem_arb #(
  parameter int AW     = 30,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          idle;
  logic          gnt_i, gnt_d;

  // Grants are gated by reset so every output reads 0 while rst is low.
  always_comb begin
    idle  = rst && (state_q == IDLE);
    gnt_i = idle && i_req && (!d_req || (last_q == OWN_D));
    gnt_d = idle && d_req && (!i_req || (last_q == OWN_I));
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_i) begin
          addr_d  = i_addr;
          we_d    = 1'b0;
          be_d    = '1;
          wdata_d = '0;
          owner_d = OWN_I;
          last_d  = OWN_I;
          state_d = ISSUE;
        end else if (gnt_d) begin
          addr_d  = d_addr;
          we_d    = d_we;
          be_d    = d_be;
          wdata_d = d_wdata;
          owner_d = OWN_D;
          last_d  = OWN_D;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = CW'(RD_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (owner_q == OWN_I) i_rdata_d = mem_rdata;
          else                  d_rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      last_q    <= OWN_D;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    i_gnt     = gnt_i;
    d_gnt     = gnt_d;
    mem_en    = (state_q == ISSUE);
    mem_we    = (state_q == ISSUE) && we_q;
    mem_be    = be_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    i_rvalid  = (state_q == RESP) && (owner_q == OWN_I);
    d_rvalid  = (state_q == RESP) && (owner_q == OWN_D);
    i_rdata   = i_rdata_q;
    d_rdata   = d_rdata_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: two instances (RD_LAT=1 and RD_LAT=3) driven by
// randomized requesters; expectations come from a transaction-level arbitration model.
module tb_mem_arb;

  typedef struct {
    int          due;
    logic        we;
    logic [3:0]  be;
    logic [29:0] addr;
    logic [31:0] wdata;
  } mexp_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rexp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input logic [4:0] a);
    if (a == 5'd4) return 32'h0050_0093;
    return {3'b101, a, 8'h3C, ~a, 3'b011, 8'hC5};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int L = (k == 0) ? 1 : 3;

    logic        rst;
    logic        i_req, i_gnt, i_rvalid;
    logic [29:0] i_addr;
    logic [31:0] i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [3:0]  d_be;
    logic [29:0] d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic        mem_en, mem_we, busy;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    mem_arb #(.AW(30), .DW(32), .RD_LAT(L)) u_dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory with RD_LAT-cycle read pipeline; junk on the bus when no read is due.
    logic [31:0] dmem [32];
    bit          dwr  [32];
    logic [31:0] pipe [L];

    always @(posedge clk) begin
      if (mem_en && mem_we) begin
        dmem[mem_addr[4:0]] <= merge(dwr[mem_addr[4:0]] ? dmem[mem_addr[4:0]]
                                                        : init_word(mem_addr[4:0]),
                                     mem_wdata, mem_be);
        dwr[mem_addr[4:0]]  <= 1'b1;
      end
      pipe[0] <= (mem_en && !mem_we) ? (dwr[mem_addr[4:0]] ? dmem[mem_addr[4:0]]
                                                           : init_word(mem_addr[4:0]))
                                     : $urandom;
      for (int j = 1; j < L; j++) pipe[j] <= pipe[j-1];
    end
    assign mem_rdata = pipe[L-1];

    mexp_t       mq [$];
    rexp_t       iq [$];
    rexp_t       dq [$];
    logic [31:0] ihold = '0;
    logic [31:0] dhold = '0;

    always @(negedge clk) begin
      mexp_t me;
      rexp_t re;
      if (!rst) begin
        chk($sformatf("L%0d outputs in reset", L),
            {i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy}, '0);
        mq.delete(); iq.delete(); dq.delete();
        ihold = '0;
        dhold = '0;
      end else begin
        chk($sformatf("L%0d mem_we without mem_en", L), mem_we & ~mem_en, 0);
        if (mem_en) begin
          if (mq.size() == 0) chk($sformatf("L%0d spurious mem_en", L), mem_en, 0);
          else begin
            me = mq.pop_front();
            chk($sformatf("L%0d mem access we/be/addr/wdata/cycle", L),
                {mem_we, mem_be, mem_addr, mem_wdata, 32'(cyc)},
                {me.we, me.be, me.addr, me.wdata, 32'(me.due)});
          end
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
          me = mq.pop_front();
          chk($sformatf("L%0d mem_en at due cycle", L), mem_en, 1);
        end
        if (i_rvalid) begin
          if (iq.size() == 0) chk($sformatf("L%0d spurious i_rvalid", L), i_rvalid, 0);
          else begin
            re = iq.pop_front();
            ihold = re.data;
            chk($sformatf("L%0d i read data/cycle", L), {i_rdata, 32'(cyc)},
                {re.data, 32'(re.due)});
          end
        end else if (iq.size() > 0 && iq[0].due <= cyc) begin
          re = iq.pop_front();
          ihold = re.data;
          chk($sformatf("L%0d i_rvalid at due cycle", L), i_rvalid, 1);
        end
        if (d_rvalid) begin
          if (dq.size() == 0) chk($sformatf("L%0d spurious d_rvalid", L), d_rvalid, 0);
          else begin
            re = dq.pop_front();
            dhold = re.data;
            chk($sformatf("L%0d d read data/cycle", L), {d_rdata, 32'(cyc)},
                {re.data, 32'(re.due)});
          end
        end else if (dq.size() > 0 && dq[0].due <= cyc) begin
          re = dq.pop_front();
          dhold = re.data;
          chk($sformatf("L%0d d_rvalid at due cycle", L), d_rvalid, 1);
        end
        chk($sformatf("L%0d rdata hold", L), {i_rdata, d_rdata}, {ihold, dhold});
      end
    end

    // Requester state and reference model: next free cycle plus last owner (1 = D).
    int          free_at;
    bit          last;
    bit          rst_v;
    bit          i_pend, d_pend;
    logic [4:0]  ia, da;
    logic        dw;
    logic [3:0]  dbe;
    logic [31:0] dwd;
    logic [31:0] rmem [32];

    task automatic drive();
      rst     = rst_v;
      i_req   = rst_v ? i_pend : 1'($urandom);
      i_addr  = i_pend ? {25'd0, ia} : 30'($urandom);
      d_req   = rst_v ? d_pend : 1'($urandom);
      d_we    = d_pend ? dw : 1'($urandom);
      d_be    = d_pend ? dbe : 4'($urandom);
      d_addr  = d_pend ? {25'd0, da} : 30'($urandom);
      d_wdata = d_pend ? dwd : $urandom;
    endtask

    task automatic predict();
      bit idle, wi, wd;
      if (!rst) begin
        free_at = 0;
        last    = 1'b1;
        i_pend  = 1'b0;
        d_pend  = 1'b0;
        return;
      end
      idle = (cyc >= free_at);
      wi   = idle && i_req && (!d_req || last);
      wd   = idle && d_req && (!i_req || !last);
      chk($sformatf("L%0d i_gnt/d_gnt/busy", L), {i_gnt, d_gnt, busy}, {wi, wd, !idle});
      if (wi) begin
        mq.push_back('{cyc + 1, 1'b0, 4'hF, i_addr, 32'd0});
        iq.push_back('{cyc + L + 2, rmem[i_addr[4:0]]});
        free_at = cyc + L + 3;
        last    = 1'b0;
        i_pend  = 1'b0;
      end
      if (wd) begin
        mq.push_back('{cyc + 1, d_we, d_be, d_addr, d_wdata});
        if (d_we) begin
          rmem[d_addr[4:0]] = merge(rmem[d_addr[4:0]], d_wdata, d_be);
          free_at = cyc + 2;
        end else begin
          dq.push_back('{cyc + L + 2, rmem[d_addr[4:0]]});
          free_at = cyc + L + 3;
        end
        last   = 1'b1;
        d_pend = 1'b0;
      end
    endtask

    task automatic new_i();
      i_pend = 1'b1;
      ia     = 5'($urandom);
    endtask

    task automatic new_d();
      d_pend = 1'b1;
      dw     = 1'($urandom);
      dbe    = 4'($urandom);
      da     = 5'($urandom);
      dwd    = $urandom;
    endtask

    // mode 0: directed only, 1: random arrivals and drops, 2: both ports saturated
    task automatic step(input int mode);
      @(posedge clk);
      #1;
      if (mode == 1) begin
        if (!i_pend && $urandom_range(0, 2) == 0) new_i();
        else if (i_pend && $urandom_range(0, 19) == 0) i_pend = 1'b0;
        if (!d_pend && $urandom_range(0, 2) == 0) new_d();
        else if (d_pend && $urandom_range(0, 19) == 0) d_pend = 1'b0;
      end else if (mode == 2) begin
        if (!i_pend) new_i();
        if (!d_pend) new_d();
      end
      drive();
      @(negedge clk);
      predict();
    endtask

    task automatic drain();
      i_pend = 1'b0;
      d_pend = 1'b0;
      for (int n = 0; n < 20 && cyc < free_at + 1; n++) step(0);
      step(0);
    endtask

    initial begin : driver
      for (int a = 0; a < 32; a++) rmem[a] = init_word(5'(a));
      free_at = 0;
      last    = 1'b1;
      i_pend  = 1'b0;
      d_pend  = 1'b0;
      rst_v   = 1'b0;
      rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = '0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
      #2 rst = 1'b0;
      repeat (4) step(0);

      // Simultaneous requests out of reset: I must win.
      rst_v = 1'b1;
      i_pend = 1'b1; ia = 5'd4;
      d_pend = 1'b1; dw = 1'b0; dbe = 4'hF; da = 5'd8; dwd = 32'h0;
      step(0);
      chk($sformatf("L%0d first grant after reset", L), {i_gnt, d_gnt}, 2'b10);
      for (int n = 0; n < 20 && d_pend; n++) step(0);
      drain();

      // Store then a fetch of the same word, granted two cycles after the store.
      d_pend = 1'b1; dw = 1'b1; dbe = 4'b0011; da = 5'h10; dwd = 32'hDEAD_BEEF;
      step(0);
      i_pend = 1'b1; ia = 5'h10;
      for (int n = 0; n < 20 && i_pend; n++) step(0);
      drain();

      repeat (40) step(2);
      repeat (400) step(1);
      drain();

      // Reset while a fetch is in WAIT.
      i_pend = 1'b1; ia = 5'($urandom);
      for (int n = 0; n < 20 && i_pend; n++) step(0);
      step(0);
      step(0);
      #1 rst = 1'b0;
      rst_v = 1'b0;
      #1 chk($sformatf("L%0d outputs right after async reset", L),
             {i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
              mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy}, '0);
      step(0);
      step(0);
      rst_v = 1'b1;
      repeat (L + 4) step(0);
      i_pend = 1'b1; ia = 5'd4;
      d_pend = 1'b1; dw = 1'b0; dbe = 4'hF; da = 5'd9; dwd = 32'h0;
      step(0);
      chk($sformatf("L%0d grant after mid-read reset", L), {i_gnt, d_gnt}, 2'b10);
      for (int n = 0; n < 20 && d_pend; n++) step(0);
      drain();

      #1 chk($sformatf("L%0d scoreboard drained", L), mq.size() + iq.size() + dq.size(), 0);
      done[k] = 1'b1;
    end
  end

  initial begin : main
    for (int n = 0; n < 20000; n++) begin
      @(posedge clk);
      if (done[0] && done[1]) break;
    end
    if (!(done[0] && done[1])) begin
      checks++;
      errors++;
      $display("FAIL timeout: done=%0b%0b required 11", done[1], done[0]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Shares one single-port synchronous memory between the CPU's instruction-fetch port (I) and its load/store port (D).
- Arbitrates round-robin and sequences each access through issue, wait and response.
- Returns read data to the winning requester with a one-cycle valid pulse.
- Sits between the multicycle RV32I core's fetch/write-back sequencing and the unified instruction/data memory.

Parameters:
AW, 30, word-address width (byte address bits [31:2]).
DW, 32, data width.
RD_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range >= 1.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
i_req  in  1  fetch request; held until i_gnt.
i_addr  in  AW  fetch word address.
i_gnt  out  1  fetch grant (combinational).
i_rvalid  out  1  fetch data valid pulse.
i_rdata  out  DW  fetch read data.
d_req  in  1  load/store request; held until d_gnt.
d_we  in  1  1 = store.
d_be  in  4  byte enables.
d_addr  in  AW  data word address.
d_wdata  in  DW  store data.
d_gnt  out  1  load/store grant (combinational).
d_rvalid  out  1  load data valid pulse (loads only).
d_rdata  out  DW  load data.
mem_en  out  1  memory access strobe.
mem_we  out  1  memory write enable.
mem_be  out  4  memory byte enables.
mem_addr  out  AW  memory word address.
mem_wdata  out  DW  memory write data.
mem_rdata  in  DW  memory read data.
busy  out  1  state != IDLE.

Behaviour:
- Reset (rst low, async):
  - state=IDLE, last_owner=D, wait counter=0.
  - All mem_* outputs, i/d_rvalid and i/d_rdata = 0.
  - An in-flight read is abandoned and produces no rvalid.
- FSM states: IDLE, ISSUE, WAIT, RESP. Grants occur only in IDLE.
- Arbitration in IDLE:
  - Only one request: grant it.
  - Both requesting: grant the port that is not last_owner.
  - last_owner updates on every grant.
  - i_gnt and d_gnt are never both 1 and are 0 outside IDLE.
- Grant edge (cycle T):
  - Registers the winner's fields into mem_addr, mem_we, mem_be and mem_wdata.
  - I port is forced to we=0, be=4'hF, wdata=0.
  - Stores owner; next state = ISSUE.
- ISSUE (T+1):
  - mem_en=1 for exactly this cycle.
  - mem_we=1 only for stores.
  - Store: next state = IDLE; no rvalid. The next grant is possible at T+2.
  - Read: load counter with RD_LAT-1; next state = WAIT.
- WAIT:
  - Lasts RD_LAT cycles (T+2 .. T+1+RD_LAT).
  - On the final WAIT cycle, capture mem_rdata into the owner's rdata register.
  - Next state = RESP.
- RESP (T+2+RD_LAT):
  - owner's rvalid=1 for exactly one cycle; next state = IDLE.
- rdata registers hold their value until the next capture for the same port.
- Outside ISSUE: mem_en=0 and mem_we=0. mem_addr, mem_be and mem_wdata hold their last values.
- Read turnaround (grant to next grant) is RD_LAT+3 cycles; store turnaround is 2 cycles.
- Requests arriving or dropping while not IDLE are ignored until IDLE.
- A request dropped before being granted is never serviced.
- A request asserted in the same cycle as its grant edge is legal.

Test Plan:
- Reset values: drive rst=0 with random inputs -> all outputs 0 and busy=0. Release rst, then raise i_req and d_req together -> i_gnt wins (last_owner=D at reset).
- Single fetch, RD_LAT=1: i_req with i_addr=0x4 at cycle 0; memory model returns 0x00500093 -> i_gnt=1 in cycle 0, mem_en=1 with mem_addr=0x4 and mem_be=F in cycle 1, i_rvalid=1 with i_rdata=0x00500093 in cycle 3 only, busy=0 in cycle 4.
- Contention: i_req and d_req held continuously -> grants alternate I, D, I, D; never both granted; each read sees rvalid exactly RD_LAT+2 cycles after its grant.
- Store: d_req, d_we=1, d_be=4'b0011, d_addr=0x10, d_wdata=0xDEADBEEF -> mem_we=1 with exact fields for one cycle; no d_rvalid; a pending i_req is granted 2 cycles after the store grant.
- Latency: RD_LAT=3, d_req load -> d_rvalid 5 cycles after grant; mem_en high only in the cycle after grant.
- Reset mid-WAIT: assert rst during WAIT of an I read -> immediate IDLE and outputs 0; no i_rvalid after release; the next simultaneous request is granted to I.
